mult_div_unit: RTL and testbench

- Parametrised iterative multiply/divide engine. It replaces the separate fixed 32-bit Mult and Div blocks with one shared datapath.
- Feeds the HI/LO register pair of the CPU.
- Adds:
  - configurable operand width
  - signed/unsigned mode
  - fixed-latency radix-2 shift-subtract division (no repeated subtraction)
  - explicit Start/Busy/Done handshake

---
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider that shares one datapath and feeds the CPU HI/LO pair.
// Sign handling works on magnitudes; the sign fixup is applied only when the results are registered in FINISH.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic             OpDiv,
    input  logic             SignedMode,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             Busy,
    output logic             Done,
    output logic             Div0,
    output logic [WIDTH-1:0] HIOut,
    output logic [WIDTH-1:0] LOOut
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

    state_t           r_state;
    logic             r_op_div;
    logic             r_signed;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi_out;
    logic [WIDTH-1:0] r_lo_out;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_in_mag_a;
    logic [WIDTH-1:0] w_in_mag_b;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_mul_hi;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic             w_div0;

    assign w_a_neg    = SignedMode & OpA[WIDTH-1];
    assign w_b_neg    = SignedMode & OpB[WIDTH-1];
    assign w_in_mag_a = w_a_neg ? -OpA : OpA;
    assign w_in_mag_b = w_b_neg ? -OpB : OpB;

    // Multiply: r_hi holds the upper half plus carry, r_lo the shrinking multiplier.
    assign w_add    = r_hi + {1'b0, r_mag_a};
    assign w_mul_hi = r_lo[0] ? w_add : r_hi;

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_trial = {1'b0, w_shift} - {2'b00, r_mag_b};

    assign w_prod     = {r_hi[WIDTH-1:0], r_lo};
    assign w_prod_fix = (r_signed & (r_sign_a ^ r_sign_b)) ? -w_prod : w_prod;
    assign w_quot     = (r_signed & (r_sign_a ^ r_sign_b)) ? -r_lo : r_lo;
    assign w_rem      = (r_signed & r_sign_a) ? -r_hi[WIDTH-1:0] : r_hi[WIDTH-1:0];
    assign w_div0     = r_op_div & (r_mag_b == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op_div <= 1'b0;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_hi_out <= '0;
            r_lo_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_op_div <= OpDiv;
                        r_signed <= SignedMode;
                        r_sign_a <= w_a_neg;
                        r_sign_b <= w_b_neg;
                        r_mag_a  <= w_in_mag_a;
                        r_mag_b  <= w_in_mag_b;
                        r_cnt    <= '0;
                        r_div0   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_hi     <= '0;
                        // Divide-by-zero keeps the raw dividend in r_lo for HIOut.
                        if (OpDiv && (OpB == '0)) begin
                            r_lo    <= OpA;
                            r_state <= S_FINISH;
                        end else begin
                            r_lo    <= OpDiv ? w_in_mag_a : w_in_mag_b;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (!r_op_div) begin
                        r_hi <= {1'b0, w_mul_hi[WIDTH:1]};
                        r_lo <= {w_mul_hi[0], r_lo[WIDTH-1:1]};
                    end else if (!w_trial[WIDTH+1]) begin
                        r_hi <= w_trial[WIDTH:0];
                        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_hi <= w_shift;
                        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (w_div0) begin
                        r_div0   <= 1'b1;
                        r_hi_out <= r_lo;
                        r_lo_out <= '1;
                    end else if (r_op_div) begin
                        r_hi_out <= w_rem;
                        r_lo_out <= w_quot;
                    end else begin
                        r_hi_out <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo_out <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy  = r_busy;
    assign Done  = r_done;
    assign Div0  = r_div0;
    assign HIOut = r_hi_out;
    assign LOOut = r_lo_out;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised bench for mult_div_unit (WIDTH=32 and WIDTH=8) against an arithmetic reference model.
module tb_mult_div_unit;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        s32_start = 1'b0, s32_div = 1'b0, s32_sgn = 1'b0;
    logic [31:0] s32_a = '0, s32_b = '0;
    logic        s32_busy, s32_done, s32_div0;
    logic [31:0] s32_hi, s32_lo;

    logic        s8_start = 1'b0, s8_div = 1'b0, s8_sgn = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic        s8_busy, s8_done, s8_div0;
    logic [7:0]  s8_hi, s8_lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.WIDTH(32)) u_dut32 (
        .clock(clock), .reset(reset), .Start(s32_start), .OpDiv(s32_div), .SignedMode(s32_sgn),
        .OpA(s32_a), .OpB(s32_b), .Busy(s32_busy), .Done(s32_done), .Div0(s32_div0),
        .HIOut(s32_hi), .LOOut(s32_lo)
    );

    mult_div_unit #(.WIDTH(8)) u_dut8 (
        .clock(clock), .reset(reset), .Start(s8_start), .OpDiv(s8_div), .SignedMode(s8_sgn),
        .OpA(s8_a), .OpB(s8_b), .Busy(s8_busy), .Done(s8_done), .Div0(s8_div0),
        .HIOut(s8_hi), .LOOut(s8_lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on sign-extended 64-bit values.
    function automatic void model(input int w, input logic div, input logic sgn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] mask, am, bm, p;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        am = {32'd0, a} & mask;
        bm = {32'd0, b} & mask;
        sa = longint'(am);
        sb = longint'(bm);
        if (sgn && am[w-1]) sa -= longint'(64'd1 << w);
        if (sgn && bm[w-1]) sb -= longint'(64'd1 << w);
        if (!div) begin
            p  = 64'(sa * sb);
            hi = 32'((p >> w) & mask);
            lo = 32'(p & mask);
        end else if (bm == 64'd0) begin
            hi = am[31:0];
            lo = mask[31:0];
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = 32'(64'(q) & mask);
            hi = 32'(64'(r) & mask);
        end
    endfunction

    task automatic drive(input int sel, input logic st, input logic div, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel == 8) begin
            s8_start = st; s8_div = div; s8_sgn = sgn; s8_a = a[7:0]; s8_b = b[7:0];
        end else begin
            s32_start = st; s32_div = div; s32_sgn = sgn; s32_a = a; s32_b = b;
        end
    endtask

    task automatic sample(input int sel, output logic bs, output logic dn, output logic d0,
                          output logic [31:0] h, output logic [31:0] l);
        if (sel == 8) begin
            bs = s8_busy; dn = s8_done; d0 = s8_div0; h = {24'd0, s8_hi}; l = {24'd0, s8_lo};
        end else begin
            bs = s32_busy; dn = s32_done; d0 = s32_div0; h = s32_hi; l = s32_lo;
        end
    endtask

    // One operation: Start at a negedge, accepted at the next posedge, then wait for Done.
    task automatic op(input int sel, input logic div, input logic sgn,
                      input logic [31:0] a, input logic [31:0] b, input bit spam);
        int w, n, bc, lat;
        logic [31:0] eh, el, ph, pl, h, l;
        logic bz, bs, dn, d0;
        bit stable;
        w  = (sel == 8) ? 8 : 32;
        model(w, div, sgn, a, b, eh, el);
        bz = div && ((w == 8) ? (b[7:0] == 8'd0) : (b == 32'd0));
        @(negedge clock);
        drive(sel, 1'b1, div, sgn, a, b);
        @(posedge clock);
        #1;
        drive(sel, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
        sample(sel, bs, dn, d0, ph, pl);
        bc = int'(bs);
        n = 0;
        stable = 1'b1;
        while (n < 100) begin
            if (spam && n < 20) drive(sel, 1'(n), 1'b1, 1'b0, $urandom, 32'd0);
            @(posedge clock);
            #1;
            n++;
            sample(sel, bs, dn, d0, h, l);
            if (dn) break;
            bc += int'(bs);
            if (h !== ph || l !== pl) stable = 1'b0;
        end
        if (spam) drive(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        lat = bz ? 1 : w + 1;
        check("latency", 64'(n), 64'(lat));
        check("busy_cycles", 64'(bc), 64'(lat));
        check("busy_at_done", 64'(bs), 64'd0);
        check("hold_during_calc", 64'(stable), 64'd1);
        check("hi", 64'(h), 64'(eh));
        check("lo", 64'(l), 64'(el));
        check("div0", 64'(d0), 64'(bz));
    endtask

    task automatic count_dones(input int sel, input int cycles, output int cnt);
        logic bs, dn, d0;
        logic [31:0] h, l;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            sample(sel, bs, dn, d0, h, l);
            cnt += int'(dn);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [31:0] ra, rb;
        #12;
        check("reset_flags32", 64'({s32_busy, s32_done, s32_div0}), 64'd0);
        check("reset_hi32", 64'(s32_hi), 64'd0);
        check("reset_lo32", 64'(s32_lo), 64'd0);
        check("reset_flags8", 64'({s8_busy, s8_done, s8_div0}), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        op(32, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd3, 1'b0);
        op(32, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        op(32, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        op(32, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd3, 1'b0);
        op(32, 1'b1, 1'b1, 32'd7, 32'hFFFFFFFD, 1'b0);
        op(32, 1'b1, 1'b0, 32'hFFFFFFF9, 32'd3, 1'b0);
        op(32, 1'b1, 1'b0, 32'h12345678, 32'd0, 1'b0);
        op(32, 1'b0, 1'b0, 32'd5, 32'd6, 1'b0);
        op(32, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        op(32, 1'b1, 1'b1, 32'h80000000, 32'd0, 1'b0);

        op(32, 1'b0, 1'b0, 32'h1234, 32'h5678, 1'b1);
        count_dones(32, 40, cnt);
        check("ignored_start_dones", 64'(cnt), 64'd0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'($urandom_range(1, 7));
                default: ;
            endcase
            op(32, 1'($urandom), 1'($urandom), ra, rb, 1'b0);
        end

        @(negedge clock);
        drive(32, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h01234567);
        @(posedge clock);
        #1;
        drive(32, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_flags", 64'({s32_busy, s32_done, s32_div0}), 64'd0);
        check("abort_hi", 64'(s32_hi), 64'd0);
        check("abort_lo", 64'(s32_lo), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        count_dones(32, 40, cnt);
        check("abort_no_done", 64'(cnt), 64'd0);
        op(32, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);

        op(8, 1'b0, 1'b1, 32'h80, 32'h80, 1'b0);
        op(8, 1'b1, 1'b1, 32'h80, 32'hFF, 1'b0);
        op(8, 1'b1, 1'b0, 32'h5A, 32'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            op(8, 1'($urandom), 1'($urandom), $urandom, 32'($urandom_range(0, 255)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
